seg_scan_ctrl: RTL and testbench

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

---
 rtl/seg_scan_ctrl.sv | 97 +++++++++
 tb/tb_seg_scan_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 8-digit display scanner: a prescaler times the digit slots, and a
// shadow/active digit file with frame-aligned commit drives registered Q and anode outputs.
module seg_scan_ctrl #(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned BLANK_CYC   = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       wr_en,
    input  logic [2:0] wr_addr,
    input  logic [3:0] wr_data,
    input  logic       commit,
    input  logic [7:0] en_mask,
    output logic [3:0] Q,
    output logic [7:0] anode,
    output logic [2:0] digit_sel,
    output logic       commit_pending,
    output logic       frame_tick
);

    localparam int unsigned   PW        = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] BLANK_END = PW'(BLANK_CYC);

    logic [PW-1:0]   presc_q, presc_d;
    logic [2:0]      digit_sel_q, digit_sel_d;
    logic [7:0][3:0] shadow_q, shadow_d;
    logic [7:0][3:0] active_q, active_d;
    logic            pending_q, pending_d;
    logic            frame_tick_q, frame_tick_d;
    logic [3:0]      q_q, q_d;
    logic [7:0]      anode_q, anode_d;
    logic            slot_tick;
    logic            wrap;

    always_comb begin
        slot_tick   = (presc_q == PRESC_MAX);
        wrap        = slot_tick && (digit_sel_q == 3'd7);
        presc_d     = slot_tick ? '0 : presc_q + PW'(1);
        digit_sel_d = slot_tick ? digit_sel_q + 3'd1 : digit_sel_q;

        // The copy reads shadow_q, so a write landing on the wrap edge stays in shadow only
        shadow_d = shadow_q;
        if (wr_en) begin
            shadow_d[wr_addr] = wr_data;
        end
        active_d = active_q;
        if (wrap && pending_q) begin
            active_d = shadow_q;
        end

        pending_d = pending_q;
        if (commit) begin
            pending_d = 1'b1;
        end else if (wrap) begin
            pending_d = 1'b0;
        end

        frame_tick_d = wrap;

        // Outputs are computed from next-state values so Q, anode and digit_sel move together
        q_d = en_mask[digit_sel_d] ? active_d[digit_sel_d] : 4'hF;
        anode_d = '1;
        if ((presc_d >= BLANK_END) && en_mask[digit_sel_d]) begin
            anode_d[digit_sel_d] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_q      <= '0;
            digit_sel_q  <= '0;
            shadow_q     <= '0;
            active_q     <= '0;
            pending_q    <= 1'b0;
            frame_tick_q <= 1'b0;
            q_q          <= '0;
            anode_q      <= '1;
        end else begin
            presc_q      <= presc_d;
            digit_sel_q  <= digit_sel_d;
            shadow_q     <= shadow_d;
            active_q     <= active_d;
            pending_q    <= pending_d;
            frame_tick_q <= frame_tick_d;
            q_q          <= q_d;
            anode_q      <= anode_d;
        end
    end

    assign Q              = q_q;
    assign anode          = anode_q;
    assign digit_sel      = digit_sel_q;
    assign commit_pending = pending_q;
    assign frame_tick     = frame_tick_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed and randomised checks of seg_scan_ctrl with REFRESH_DIV=4, BLANK_CYC=1;
// expected values come from hand tables and a cycle-count based reference model.
module tb_seg_scan_ctrl;

    localparam int unsigned RD = 4;
    localparam int unsigned BC = 1;
    localparam int unsigned FRAME = RD * 8;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [3:0] wr_data;
    logic       commit;
    logic [7:0] en_mask;
    logic [3:0] Q;
    logic [7:0] anode;
    logic [2:0] digit_sel;
    logic       commit_pending;
    logic       frame_tick;

    int          n_checks = 0;
    int          n_fail   = 0;
    int unsigned n;
    logic [3:0]  m_sh  [8];
    logic [3:0]  m_act [8];
    logic        m_pend;
    logic [7:0]  m_mask;
    logic [7:0]  tbl   [8];

    seg_scan_ctrl #(.REFRESH_DIV(RD), .BLANK_CYC(BC)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .commit         (commit),
        .en_mask        (en_mask),
        .Q              (Q),
        .anode          (anode),
        .digit_sel      (digit_sel),
        .commit_pending (commit_pending),
        .frame_tick     (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, n);
        end
    endtask

    task automatic model_reset();
        n      = 0;
        m_pend = 1'b0;
        for (int i = 0; i < 8; i++) begin
            m_sh[i]  = 4'h0;
            m_act[i] = 4'h0;
        end
    endtask

    task automatic check_outputs();
        int unsigned d;
        int unsigned p;
        logic [7:0]  a_exp;
        logic [3:0]  q_exp;
        d     = (n / RD) % 8;
        p     = n % RD;
        a_exp = 8'hFF;
        if (n == 0) q_exp = 4'h0;
        else        q_exp = m_mask[d] ? m_act[d] : 4'hF;
        if (n != 0 && p >= BC && m_mask[d]) a_exp[d] = 1'b0;
        check_eq("digit_sel", 32'(digit_sel), d);
        check_eq("Q", 32'(Q), 32'(q_exp));
        check_eq("anode", 32'(anode), 32'(a_exp));
        check_eq("frame_tick", 32'(frame_tick), 32'((n != 0) && (n % FRAME == 0)));
        check_eq("commit_pending", 32'(commit_pending), 32'(m_pend));
        check_eq("one_anode_max", 32'($countones(~anode) <= 1), 32'd1);
    endtask

    task automatic tick();
        int unsigned e;
        logic        wrap;
        e    = n + 1;
        wrap = (e % FRAME == 0);
        if (wrap && m_pend) begin
            for (int i = 0; i < 8; i++) m_act[i] = m_sh[i];
        end
        if (wr_en) m_sh[wr_addr] = wr_data;
        if (commit)    m_pend = 1'b1;
        else if (wrap) m_pend = 1'b0;
        m_mask = en_mask;
        @(posedge clk);
        @(negedge clk);
        n = e;
        check_outputs();
    endtask

    task automatic goto_pos(input int unsigned pos);
        for (int k = 0; k < int'(FRAME); k++) begin
            if (n % FRAME == pos) break;
            tick();
        end
    endtask

    task automatic write_digit(input logic [2:0] a, input logic [3:0] v);
        wr_en = 1'b1; wr_addr = a; wr_data = v;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic do_commit();
        commit = 1'b1;
        tick();
        commit = 1'b0;
    endtask

    initial begin
        tbl = '{8'hFE, 8'hFE, 8'hFE, 8'hFF, 8'hFD, 8'hFD, 8'hFD, 8'hFF};
        reset_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        commit = 1'b0; en_mask = 8'hFF;
        model_reset();
        repeat (2) @(negedge clk);
        check_eq("rst_anode", 32'(anode), 32'hFF);
        check_eq("rst_Q", 32'(Q), 32'h0);
        check_eq("rst_digit", 32'(digit_sel), 32'h0);
        check_eq("rst_pending", 32'(commit_pending), 32'h0);
        check_eq("rst_frame", 32'(frame_tick), 32'h0);
        reset_n = 1'b1;
        m_mask  = en_mask;
        check_outputs();

        // Blanking/anode walk after reset release
        for (int k = 0; k < 8; k++) begin
            tick();
            check_eq("anode_walk", 32'(anode), 32'(tbl[k]));
        end
        goto_pos(0);
        check_eq("wrap_frame_tick", 32'(frame_tick), 32'h1);

        // Load 1..8, commit mid-frame; duplicate commit must not queue a second copy
        goto_pos(3);
        for (int i = 0; i < 8; i++) write_digit(3'(i), 4'(i + 1));
        do_commit();
        do_commit();
        check_eq("Q_before_wrap", 32'(Q), 32'h0);
        goto_pos(0);
        check_eq("pending_cleared", 32'(commit_pending), 32'h0);
        check_eq("Q_slot0_after", 32'(Q), 32'h1);
        goto_pos(13);
        check_eq("Q_slot3_after", 32'(Q), 32'h4);

        // Write + commit on the exact wrap edge while a commit is pending
        do_commit();
        goto_pos(FRAME - 1);
        wr_en = 1'b1; wr_addr = 3'd3; wr_data = 4'd9; commit = 1'b1;
        tick();
        wr_en = 1'b0; commit = 1'b0;
        check_eq("pending_kept", 32'(commit_pending), 32'h1);
        goto_pos(13);
        check_eq("Q_slot3_old", 32'(Q), 32'h4);
        goto_pos(0);
        goto_pos(13);
        check_eq("Q_slot3_new", 32'(Q), 32'h9);
        check_eq("pending_done", 32'(commit_pending), 32'h0);

        // Partial enable mask
        en_mask = 8'b0000_0101;
        goto_pos(1);
        check_eq("mask_anode_s0", 32'(anode), 32'hFE);
        goto_pos(5);
        check_eq("mask_anode_s1", 32'(anode), 32'hFF);
        check_eq("mask_Q_s1", 32'(Q), 32'hF);
        goto_pos(9);
        check_eq("mask_anode_s2", 32'(anode), 32'hFB);
        check_eq("mask_Q_s2", 32'(Q), 32'h3);
        en_mask = 8'h00;
        tick();
        check_eq("mask_off_now", 32'(anode), 32'hFF);
        en_mask = 8'hFF;

        // Asynchronous reset mid-slot with a commit pending
        write_digit(3'd0, 4'd7);
        do_commit();
        goto_pos(6);
        #2 reset_n = 1'b0;
        #1;
        check_eq("async_anode", 32'(anode), 32'hFF);
        check_eq("async_Q", 32'(Q), 32'h0);
        check_eq("async_pending", 32'(commit_pending), 32'h0);
        check_eq("async_digit", 32'(digit_sel), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        m_mask = en_mask;
        check_outputs();
        goto_pos(FRAME - 1);
        goto_pos(1);
        check_eq("no_copy_after_rst", 32'(Q), 32'h0);

        // Random traffic against the reference model
        for (int c = 0; c < 10000; c++) begin
            wr_en   = ($urandom_range(3, 0) == 0);
            wr_addr = 3'($urandom_range(7, 0));
            wr_data = 4'($urandom_range(15, 0));
            commit  = ($urandom_range(40, 0) == 0);
            if ($urandom_range(60, 0) == 0) en_mask = 8'($urandom_range(255, 0));
            tick();
        end
        wr_en = 1'b0; commit = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
